// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the runtime-programmable serial sequence detector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_det_pkg;

  // Default pattern capacity and the hard upper bound the mask helper supports.
  localparam int DEF_MAX_LEN   = 8;
  localparam int MAX_LEN_LIMIT = 16;

  // Detection mode encodings held in the overlap config register.
  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  // Width needed to hold a length value in 0..max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int DEF_LEN_W = len_w(DEF_MAX_LEN);

  // Mask with the low 'len' bits set; positions at or above len are ignored by the compare.
  function automatic logic [MAX_LEN_LIMIT-1:0] len_mask(input int unsigned len);
    logic [MAX_LEN_LIMIT-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LEN_LIMIT; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count reflects inc/clr one clock after the edge that samples them.
// Backpressure: none; inc is accepted every cycle and ignored once saturated.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear has priority, otherwise step up unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, asynchronously cleared by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-sequence detector (pattern, length, overlap mode) with match counter.
// Latency: y asserts one clock after the edge that samples the final pattern bit (Moore, registered).
// Backpressure: none; bits are taken whenever x_valid=1, a bit coinciding with cfg_load is dropped.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  // Configuration registers.
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;

  // Shift history, number of valid bits in it, and the registered match flag.
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               y_q, y_d;

  logic [MAX_LEN-1:0]       hist_n;
  logic [LEN_W-1:0]         fill_n;
  logic [MAX_LEN_LIMIT-1:0] diff;
  logic                     sample;
  logic                     hit;

  assign armed  = (len_q != '0);
  assign sample = x_valid & ~cfg_load;
  assign hist_n = {hist_q[MAX_LEN-2:0], x};
  assign fill_n = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

  // Differences between the would-be history and the pattern, restricted to the active length.
  assign diff = len_mask(32'(len_q)) & MAX_LEN_LIMIT'(hist_n ^ pat_q);
  assign hit  = sample & armed & (fill_n >= len_q) & (diff == '0);

  // Next state: a config load dominates; otherwise a valid bit shifts in and may end a match.
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = 1'b0;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      ovl_d  = cfg_overlap;
      fill_d = '0;
    end else if (x_valid) begin
      hist_d = hist_n;
      // Non-overlap mode restarts the fill count so the next match needs len fresh bits.
      fill_d = (hit && (ovl_q == MODE_NONOVL)) ? '0 : fill_n;
      y_d    = hit;
    end
  end

  // State registers; reset leaves the block unarmed until the next config load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= '0;
      len_q  <= '0;
      ovl_q  <= MODE_NONOVL;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
    end
  end

  assign y = y_q;

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (hit),
    .clr  (cnt_clr),
    .count(match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed scenarios plus random traffic vs a queue-based model.
// Latency: expectations are pushed per driven edge and popped 2 time units after that edge.
// Backpressure: none; the driver applies one stimulus vector every clock.
module tb_seq_detector_param;

  localparam int TB_MAX  = 8;
  localparam int TB_LENW = 4;
  localparam int TB_CNTW = 2;
  localparam int CNT_MAX = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               x = 1'b0;
  logic               x_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [TB_MAX-1:0]  cfg_pattern = '0;
  logic [TB_LENW-1:0] cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cnt_clr = 1'b0;
  logic               y;
  logic [TB_CNTW-1:0] match_count;
  logic               armed;

  seq_detector_param #(
    .MAX_LEN(TB_MAX),
    .CNT_W  (TB_CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .x_valid    (x_valid),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cnt_clr    (cnt_clr),
    .y          (y),
    .match_count(match_count),
    .armed      (armed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic               y;
    logic [TB_CNTW-1:0] cnt;
    logic               armed;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   y_seen = 0;

  // Reference model state: recent bits since the last restart, config and match count.
  bit         m_bits[$];
  logic [7:0] m_pat = '0;
  int         m_len = 0;
  bit         m_ovl = 1'b0;
  int         m_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pat = '0;
    m_len = 0;
    m_ovl = 1'b0;
    m_cnt = 0;
  endtask

  // One clock of stimulus; the model predicts the outputs seen after the coming edge.
  task automatic step(input logic xv, input logic xb, input logic cl, input logic cc,
                      input logic [7:0] cp, input logic [3:0] clen, input logic co);
    bit   hit;
    exp_t e;
    @(negedge clk);
    x_valid = xv; x = xb; cfg_load = cl; cnt_clr = cc;
    cfg_pattern = cp; cfg_len = clen; cfg_overlap = co;
    hit = 1'b0;
    if (cl) begin
      m_pat = cp;
      m_len = (int'(clen) > TB_MAX) ? TB_MAX : int'(clen);
      m_ovl = co;
      m_bits.delete();
    end else if (xv) begin
      m_bits.push_back(xb);
      if (m_bits.size() > TB_MAX) void'(m_bits.pop_front());
      if (m_len > 0 && m_bits.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
      end
      if (hit && !m_ovl) m_bits.delete();
    end
    if (cc) m_cnt = 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
    e.y = hit;
    e.cnt = TB_CNTW'(m_cnt);
    e.armed = (m_len != 0);
    exp_q.push_back(e);
  endtask

  task automatic sbit(input logic b);
    step(1'b1, b, 1'b0, 1'b0, cfg_pattern, cfg_len, cfg_overlap);
  endtask

  task automatic idle();
    step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, cfg_pattern, cfg_len, cfg_overlap);
  endtask

  task automatic clr_cnt();
    step(1'b0, 1'b0, 1'b0, 1'b1, cfg_pattern, cfg_len, cfg_overlap);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    step(1'b0, 1'b0, 1'b1, 1'b0, p, l, o);
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) sbit(bits[i]);
  endtask

  // Let the monitor consume all pending expectations, then check the pulse tally.
  task automatic settle(input string name, input int pulses);
    @(posedge clk);
    #3;
    chk(name, y_seen, pulses);
    y_seen = 0;
  endtask

  // Monitor: pop one expectation per edge that had stimulus and compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("y", int'(y), int'(e.y));
        chk("match_count", int'(match_count), int'(e.cnt));
        chk("armed", int'(armed), int'(e.armed));
        if (y === 1'b1) y_seen++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    #2;
    chk("reset_y", int'(y), 0);
    chk("reset_count", int'(match_count), 0);
    chk("reset_armed", int'(armed), 0);
    #20 rst = 1'b1;

    // Legacy 1011 non-overlapping.
    load(8'b1011, 4'd4, 1'b0);
    send(16'b1011_1011_0011, 12);
    settle("legacy_pulses", 2);
    chk("legacy_count", int'(match_count), 2);

    // Overlap vs non-overlap on 1011011.
    clr_cnt();
    load(8'b1011, 4'd4, 1'b1);
    send(16'b1011011, 7);
    settle("ovl_pulses", 2);
    chk("ovl_count", int'(match_count), 2);
    clr_cnt();
    load(8'b1011, 4'd4, 1'b0);
    send(16'b1011011, 7);
    settle("nonovl_pulses", 1);
    chk("nonovl_count", int'(match_count), 1);

    // Valid gating with gaps, pattern 110.
    load(8'b110, 4'd3, 1'b0);
    sbit(1'b1); repeat (3) idle();
    sbit(1'b1); repeat (3) idle();
    sbit(1'b0); repeat (2) idle();
    settle("gap_pulses", 1);

    // Length zero never arms.
    load(8'h00, 4'd0, 1'b1);
    send(16'h00FF, 16);
    settle("len0_pulses", 0);
    chk("len0_armed", int'(armed), 0);

    // Oversized length clamps to MAX_LEN.
    load(8'hA5, 4'(TB_MAX + 3), 1'b0);
    send(16'hA5, 8);
    settle("clamp_pulses", 1);
    chk("clamp_armed", int'(armed), 1);

    // Load on the final bit drops it and empties the history.
    load(8'b1011, 4'd4, 1'b0);
    send(16'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'b1011, 4'd4, 1'b0);
    send(16'b011, 3);
    settle("loadlast_pulses", 0);

    // Length one, counter saturation, clear beating a hit.
    load(8'b1, 4'd1, 1'b0);
    clr_cnt();
    send(16'b11111, 5);
    step(1'b1, 1'b1, 1'b0, 1'b1, cfg_pattern, cfg_len, cfg_overlap);
    settle("len1_pulses", 6);
    chk("clr_hit_count", int'(match_count), 0);

    // Asynchronous reset in the middle of a sequence.
    load(8'b1011, 4'd4, 1'b0);
    send(16'b1011_101, 7);
    settle("prereset_pulses", 1);
    rst = 1'b0;
    #1;
    chk("midreset_y", int'(y), 0);
    chk("midreset_count", int'(match_count), 0);
    chk("midreset_armed", int'(armed), 0);
    model_reset();
    #3 rst = 1'b1;
    idle();
    load(8'b1011, 4'd4, 1'b0);
    send(16'b1011, 4);
    settle("postreset_pulses", 1);

    // Random traffic with occasional reconfiguration and clears.
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 8'($urandom),
             ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(1, 3)),
             1'($urandom_range(0, 1)));
      end else begin
        step(1'(r % 5 != 0), 1'($urandom_range(0, 1)), 1'b0, 1'(r >= 97),
             cfg_pattern, cfg_len, cfg_overlap);
      end
    end
    @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
